// File: rtl/down_timer.sv
// Loadable countdown timer with prescaler, one-shot/auto-reload modes and pause/resume.
// Q, busy and done all come straight from flops; there are no combinational input-to-output paths.
module down_timer #(
    parameter int WIDTH = 8,
    parameter int PW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] data,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_rld,
    input  logic [PW-1:0]    presc,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [WIDTH-1:0] Q_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    P_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [PW-1:0]    p_q, p_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             tick;

    // >= rather than == so that lowering presc mid-run ticks at once instead of overrunning.
    assign tick = (p_q >= presc);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        p_d     = p_q;
        done_d  = 1'b0;

        if (ld) begin
            r_d     = data;
            q_d     = data;
            p_d     = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!stop && start) begin
                        if (q_q == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                            p_d     = '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        p_d = '0;
                        if (q_q == Q_ONE) begin
                            done_d = 1'b1;
                            if (auto_rld) begin
                                q_d = r_q;
                            end else begin
                                q_d     = '0;
                                state_d = ST_IDLE;
                            end
                        end else if (q_q != '0) begin
                            q_d = q_q - Q_ONE;
                        end
                    end else begin
                        p_d = p_q + P_ONE;
                    end
                    // The RUN edge still counts; stop only decides where the next cycle is spent.
                    if (stop && state_d == ST_RUN) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stop && start) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            p_q     <= p_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign Q    = q_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
